// File: rtl/servo_ramp_sched_pkg.sv
// rtl/servo_ramp_sched_pkg.sv - shared types and sizing helpers for the servo ramp scheduler
package servo_ramp_sched_pkg;

   // Scheduler states: IDLE takes commands, UPDATE walks the channels one per cycle.
   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_UPDATE = 1'b1
   } state_t;

   // Channel index width, never narrower than one bit.
   function automatic int ch_width(input int num_ch);
      return (num_ch < 2) ? 1 : $clog2(num_ch);
   endfunction

   // Clock ticks per PWM frame; 64-bit intermediate so large clocks do not overflow.
   function automatic int period_ticks(input int clk_freq_hz, input int pwm_period_us);
      longint t;
      t = longint'(pwm_period_us) * longint'(clk_freq_hz) / longint'(1000000);
      return int'(t);
   endfunction

endpackage

// File: rtl/servo_ramp_sched_frame_timer.sv
// rtl/servo_ramp_sched_frame_timer.sv - free-running frame counter with registered end-of-frame pulse
module servo_ramp_sched_frame_timer
   import servo_ramp_sched_pkg::*;
#(
   parameter int CLK_FREQ_HZ   = 12000000,
   parameter int PWM_PERIOD_US = 20000
) (
   input  logic clk,
   input  logic rst_n,
   output logic frame_tick
);

   localparam int PERIOD_TICKS = period_ticks(CLK_FREQ_HZ, PWM_PERIOD_US);
   localparam int CTR_W        = $clog2(PERIOD_TICKS);
   localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(PERIOD_TICKS - 1);
   localparam logic [CTR_W-1:0] CTR_PRE  = CTR_W'(PERIOD_TICKS - 2);

   logic [CTR_W-1:0] ctr;

   // Count 0..PERIOD_TICKS-1; the pulse is set one edge early so it is high while ctr sits on its last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctr        <= '0;
         frame_tick <= 1'b0;
      end else begin
         ctr        <= (ctr == CTR_LAST) ? '0 : ctr + 1'b1;
         frame_tick <= (ctr == CTR_PRE);
      end
   end

endmodule

// File: rtl/servo_ramp_sched.sv
// rtl/servo_ramp_sched.sv - per-channel duty slew scheduler feeding the servo pwm generators
module servo_ramp_sched
   import servo_ramp_sched_pkg::*;
#(
   parameter int CLK_FREQ_HZ   = 12000000,
   parameter int PWM_PERIOD_US = 20000,
   parameter int DUTY_RES_BITS = 8,
   parameter int NUM_CH        = 4,
   parameter int STEP          = 1,
   parameter int DUTY_INIT     = 128,
   localparam int CH_W         = ch_width(NUM_CH)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic [CH_W-1:0]                 cmd_ch,
   input  logic [DUTY_RES_BITS-1:0]        cmd_duty,
   input  logic                            cmd_en,
   output logic [NUM_CH*DUTY_RES_BITS-1:0] duty_bus,
   output logic [NUM_CH-1:0]               enable_bus,
   output logic                            frame_tick,
   output logic                            busy
);

   localparam int DW = DUTY_RES_BITS;
   localparam logic [DW-1:0]   INIT_DUTY = DW'(DUTY_INIT);
   localparam logic [CH_W-1:0] LAST_IDX  = CH_W'(NUM_CH - 1);

   logic [DW-1:0]     target     [NUM_CH];
   logic [DW-1:0]     cur        [NUM_CH];
   logic [NUM_CH-1:0] en;
   logic [DW-1:0]     target_nxt [NUM_CH];
   logic [DW-1:0]     cur_nxt    [NUM_CH];
   logic [NUM_CH-1:0] en_nxt;
   logic              busy_nxt;
   logic              accept;
   state_t            state;
   logic [CH_W-1:0]   idx;

   // Move c toward t by at most STEP; land exactly on t when close enough so it never overshoots or wraps.
   function automatic logic [DW-1:0] slew(input logic [DW-1:0] c, input logic [DW-1:0] t);
      logic [DW:0] diff;
      if (t >= c) diff = {1'b0, t} - {1'b0, c};
      else        diff = {1'b0, c} - {1'b0, t};
      if (STEP == 0 || int'(diff) <= STEP) return t;
      else if (t > c)                      return c + DW'(STEP);
      else                                 return c - DW'(STEP);
   endfunction

   servo_ramp_sched_frame_timer #(
      .CLK_FREQ_HZ   (CLK_FREQ_HZ),
      .PWM_PERIOD_US (PWM_PERIOD_US)
   ) u_frame_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick)
   );

   assign accept = cmd_valid && cmd_ready;

   // Next values of the channel registers: command write (out-of-range channels match nothing) and the slot slew.
   always_comb begin
      busy_nxt = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         target_nxt[i] = target[i];
         en_nxt[i]     = en[i];
         cur_nxt[i]    = cur[i];
         if (accept && cmd_ch == CH_W'(i)) begin
            target_nxt[i] = cmd_duty;
            en_nxt[i]     = cmd_en;
         end
         if (state == S_UPDATE && idx == CH_W'(i)) begin
            cur_nxt[i] = slew(cur[i], target[i]);
         end
         if (en_nxt[i] && cur_nxt[i] != target_nxt[i]) begin
            busy_nxt = 1'b1;
         end
      end
   end

   // Per-channel target, current position and enable registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            target[i] <= INIT_DUTY;
            cur[i]    <= INIT_DUTY;
         end
         en <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            target[i] <= target_nxt[i];
            cur[i]    <= cur_nxt[i];
         end
         en <= en_nxt;
      end
   end

   // Scheduler FSM: one channel per cycle after each frame tick; busy refreshed on commands and at sweep end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         idx       <= '0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) busy <= busy_nxt;
               if (frame_tick) begin
                  state     <= S_UPDATE;
                  idx       <= '0;
                  cmd_ready <= 1'b0;
               end
            end
            S_UPDATE: begin
               if (idx == LAST_IDX) begin
                  state     <= S_IDLE;
                  idx       <= '0;
                  cmd_ready <= 1'b1;
                  busy      <= busy_nxt;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
               state     <= S_IDLE;
               idx       <= '0;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

   // Flatten the registered positions onto the duty bus.
   always_comb begin
      duty_bus = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         duty_bus[i*DW +: DW] = cur[i];
      end
   end

   assign enable_bus = en;

endmodule

// File: tb/tb_servo_ramp_sched.sv
// tb/tb_servo_ramp_sched.sv - directed self-checking bench for servo_ramp_sched
module tb_servo_ramp_sched;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        cmd_valid, cmd_ready, cmd_en, frame_tick, busy;
   logic [1:0]  cmd_ch;
   logic [7:0]  cmd_duty;
   logic [31:0] duty_bus;
   logic [3:0]  enable_bus;

   logic        cmd_valid3, cmd_ready3, cmd_en3, frame_tick3, busy3;
   logic [1:0]  cmd_ch3;
   logic [7:0]  cmd_duty3;
   logic [23:0] duty_bus3;
   logic [2:0]  enable_bus3;

   int vectors     = 0;
   int miscompares = 0;
   int lows;
   int n;

   always #5 clk = ~clk;

   servo_ramp_sched #(
      .CLK_FREQ_HZ(1000000), .PWM_PERIOD_US(20), .DUTY_RES_BITS(8),
      .NUM_CH(4), .STEP(4), .DUTY_INIT(128)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ch(cmd_ch), .cmd_duty(cmd_duty), .cmd_en(cmd_en), .duty_bus(duty_bus),
      .enable_bus(enable_bus), .frame_tick(frame_tick), .busy(busy)
   );

   servo_ramp_sched #(
      .CLK_FREQ_HZ(1000000), .PWM_PERIOD_US(20), .DUTY_RES_BITS(8),
      .NUM_CH(3), .STEP(0), .DUTY_INIT(128)
   ) dut3 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
      .cmd_ch(cmd_ch3), .cmd_duty(cmd_duty3), .cmd_en(cmd_en3), .duty_bus(duty_bus3),
      .enable_bus(enable_bus3), .frame_tick(frame_tick3), .busy(busy3)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] d(input int i);
      return duty_bus[i*8 +: 8];
   endfunction

   function automatic logic [7:0] d3(input int i);
      return duty_bus3[i*8 +: 8];
   endfunction

   task automatic advance(input int k);
      repeat (k) @(negedge clk);
   endtask

   // Step negedges until the selected frame_tick is seen high, bounded.
   task automatic wait_tick(input bit sel, input string tag);
      int k = 0;
      logic t;
      do begin
         @(negedge clk);
         k++;
         t = sel ? frame_tick3 : frame_tick;
      end while (!t && k < 40);
      check(tag, 64'(t), 64'd1);
   endtask

   // Hold a command until it is accepted; lows counts cycles spent waiting on cmd_ready.
   task automatic send(input bit sel, input logic [1:0] ch, input logic [7:0] duty,
                       input logic en, output int low_cnt);
      logic rdy;
      int   k = 0;
      low_cnt = 0;
      if (sel) begin
         cmd_ch3 = ch; cmd_duty3 = duty; cmd_en3 = en; cmd_valid3 = 1'b1;
      end else begin
         cmd_ch = ch; cmd_duty = duty; cmd_en = en; cmd_valid = 1'b1;
      end
      do begin
         rdy = sel ? cmd_ready3 : cmd_ready;
         if (!rdy) low_cnt++;
         @(negedge clk);
         k++;
      end while (!rdy && k < 40);
      check("send_accept", 64'(rdy), 64'd1);
      cmd_valid  = 1'b0;
      cmd_valid3 = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_ch = '0; cmd_duty = '0; cmd_en = 1'b0;
      cmd_valid3 = 1'b0; cmd_ch3 = '0; cmd_duty3 = '0; cmd_en3 = 1'b0;

      // Reset values
      advance(3);
      check("rst_duty", 64'(duty_bus), 64'h80808080);
      check("rst_enable", 64'(enable_bus), 64'd0);
      check("rst_ready", 64'(cmd_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_tick", 64'(frame_tick), 64'd0);
      rst_n = 1'b1;

      // First frame tick position
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_tick && n < 40);
      check("first_tick_cycle", 64'(n), 64'd19);
      advance(5);

      // Ramp up ch1 to 140 by 4 per frame
      send(1'b0, 2'd1, 8'd140, 1'b1, lows);
      check("ramp_enable", 64'(enable_bus), 64'b0010);
      check("ramp_busy_set", 64'(busy), 64'd1);
      check("ramp_no_move", 64'(d(1)), 64'd128);
      wait_tick(1'b0, "tick_f1");
      advance(5);
      check("ramp_f1", 64'(d(1)), 64'd132);
      check("ramp_f1_busy", 64'(busy), 64'd1);
      wait_tick(1'b0, "tick_f2");
      advance(5);
      check("ramp_f2", 64'(d(1)), 64'd136);
      wait_tick(1'b0, "tick_f3");
      advance(2);
      check("ramp_slot_wait", 64'(d(1)), 64'd136);
      advance(1);
      check("ramp_f3", 64'(d(1)), 64'd140);
      check("ramp_busy_hold", 64'(busy), 64'd1);
      advance(2);
      check("ramp_busy_clear", 64'(busy), 64'd0);

      // Downward move smaller than STEP lands exactly; disabled channel does not raise busy
      send(1'b0, 2'd2, 8'd125, 1'b0, lows);
      check("down_busy", 64'(busy), 64'd0);
      wait_tick(1'b0, "tick_down");
      advance(5);
      check("down_ch2", 64'(d(2)), 64'd125);
      check("down_busy_after", 64'(busy), 64'd0);
      check("down_enable", 64'(enable_bus), 64'b0010);

      // Command on the tick cycle is used by that same sweep
      wait_tick(1'b0, "tick_coll");
      send(1'b0, 2'd0, 8'd136, 1'b1, lows);
      check("coll_no_wait", 64'(lows), 64'd0);
      check("coll_enable", 64'(enable_bus), 64'b0011);
      advance(1);
      check("coll_ch0", 64'(d(0)), 64'd132);
      advance(3);
      check("coll_busy", 64'(busy), 64'd1);
      check("coll_ready", 64'(cmd_ready), 64'd1);

      // Backpressure during UPDATE: held command lands on the first IDLE cycle
      wait_tick(1'b0, "tick_bp");
      advance(1);
      send(1'b0, 2'd3, 8'd100, 1'b1, lows);
      check("bp_low_cycles", 64'(lows), 64'd4);
      check("bp_enable", 64'(enable_bus), 64'b1011);
      check("bp_ch3_hold", 64'(d(3)), 64'd128);
      check("bp_ch0", 64'(d(0)), 64'd136);
      wait_tick(1'b0, "tick_bp2");
      advance(5);
      check("bp_ch3_move", 64'(d(3)), 64'd124);
      check("bp_ch0_settled", 64'(d(0)), 64'd136);
      check("bp_busy", 64'(busy), 64'd1);

      // Two commands to one channel before a frame: last one wins
      send(1'b0, 2'd2, 8'd200, 1'b0, lows);
      send(1'b0, 2'd2, 8'd130, 1'b0, lows);
      wait_tick(1'b0, "tick_lw");
      advance(5);
      check("lastwins_ch2", 64'(d(2)), 64'd129);
      check("lastwins_ch3", 64'(d(3)), 64'd120);

      // Reset in the middle of a sweep (idx 2)
      wait_tick(1'b0, "tick_mid");
      advance(3);
      rst_n = 1'b0;
      #1;
      check("midrst_duty", 64'(duty_bus), 64'h80808080);
      check("midrst_enable", 64'(enable_bus), 64'd0);
      check("midrst_ready", 64'(cmd_ready), 64'd1);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_tick", 64'(frame_tick), 64'd0);
      advance(3);
      rst_n = 1'b1;
      advance(1);

      // Three-channel, no-ramp build: out-of-range channel dropped, snap in one frame
      send(1'b1, 2'd3, 8'd50, 1'b1, lows);
      check("bad_ch_duty", 64'(duty_bus3), 64'h808080);
      check("bad_ch_enable", 64'(enable_bus3), 64'd0);
      check("bad_ch_busy", 64'(busy3), 64'd0);
      check("bad_ch_ready", 64'(cmd_ready3), 64'd1);
      send(1'b1, 2'd1, 8'd200, 1'b1, lows);
      check("snap_enable", 64'(enable_bus3), 64'b010);
      check("snap_busy_set", 64'(busy3), 64'd1);
      wait_tick(1'b1, "tick_snap");
      advance(3);
      check("snap_ch1", 64'(d3(1)), 64'd200);
      advance(1);
      check("snap_busy_clear", 64'(busy3), 64'd0);
      check("snap_ch0", 64'(d3(0)), 64'd128);
      check("snap_ch2", 64'(d3(2)), 64'd128);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
